// File: rtl/regfile_bank_ctx.sv
// DEPTH x WIDTH register file: one write port, two bypassed combinational read
// ports, and a shadow bank filled or drained one entry per cycle by SAVE/RESTORE.
module regfile_bank_ctx #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic [ADDR_W-1:0] i_raddr_a,
  output logic [WIDTH-1:0]  o_rdata_a,
  input  logic [ADDR_W-1:0] i_raddr_b,
  output logic [WIDTH-1:0]  o_rdata_b,
  input  logic              i_save,
  input  logic              i_restore,
  output logic              o_busy,
  output logic              o_done,
  output logic [1:0]        o_state
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SAVE    = 2'd1,
    ST_RESTORE = 2'd2
  } state_t;

  // Handshake: a request (save/restore) is accepted only in a cycle where
  // o_busy=0; o_busy then stays high for DEPTH cycles and o_done pulses for
  // one cycle afterwards. Writes presented while o_busy=1 are discarded.

  logic [WIDTH-1:0]  r_main   [DEPTH];
  logic [WIDTH-1:0]  r_shadow [DEPTH];
  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] w_idx_nxt;
  logic              r_busy;
  logic              r_done;
  logic              w_done_nxt;
  logic              w_wr_en;
  logic              w_last;

  assign w_wr_en = i_we && !r_busy;
  assign w_last  = (r_idx == ADDR_W'(DEPTH - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_save) begin
          w_state_nxt = ST_SAVE;
          w_idx_nxt   = '0;
        end else if (i_restore) begin
          w_state_nxt = ST_RESTORE;
          w_idx_nxt   = '0;
        end
      end
      ST_SAVE, ST_RESTORE: begin
        w_idx_nxt = r_idx + 1'b1;
        if (w_last) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_idx_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_main[i]   <= '0;
        r_shadow[i] <= '0;
      end
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_done  <= w_done_nxt;
      // Writes only land in IDLE, so they never collide with a RESTORE copy.
      if (w_wr_en) r_main[i_waddr] <= i_wdata;
      if (r_state == ST_SAVE)    r_shadow[r_idx] <= r_main[r_idx];
      if (r_state == ST_RESTORE) r_main[r_idx]   <= r_shadow[r_idx];
    end
  end

  assign o_rdata_a = (w_wr_en && (i_waddr == i_raddr_a)) ? i_wdata : r_main[i_raddr_a];
  assign o_rdata_b = (w_wr_en && (i_waddr == i_raddr_b)) ? i_wdata : r_main[i_raddr_b];
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_state   = r_state;

endmodule

// File: tb/tb_regfile_bank_ctx.sv
// Bench for regfile_bank_ctx: directed vector table, context-copy sequences,
// and randomized traffic checked against a cycle-level array model.
module tb_regfile_bank_ctx;

  logic        i_clk;
  logic        tb_rst, tb_we, tb_sv, tb_rs;
  logic [2:0]  tb_wa, tb_ra, tb_rb;
  logic [15:0] tb_wd;
  logic [15:0] o_rdata_a, o_rdata_b;
  logic        o_busy, o_done;
  logic [1:0]  o_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] m_main   [8];
  logic [15:0] m_shadow [8];
  int          m_phase;  // 0 idle, 1 save, 2 restore
  int          m_cnt;    // entries copied so far
  logic        m_done;

  typedef struct {
    logic        we;
    logic [2:0]  wa;
    logic [15:0] wd;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [15:0] ea;
    logic [15:0] eb;
  } vec_t;
  vec_t tbl[6];

  regfile_bank_ctx #(.WIDTH(16), .ADDR_W(3)) dut (
    .i_clk(i_clk), .i_rst(tb_rst), .i_we(tb_we), .i_waddr(tb_wa), .i_wdata(tb_wd),
    .i_raddr_a(tb_ra), .o_rdata_a(o_rdata_a), .i_raddr_b(tb_rb), .o_rdata_b(o_rdata_b),
    .i_save(tb_sv), .i_restore(tb_rs), .o_busy(o_busy), .o_done(o_done), .o_state(o_state)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                       input logic [2:0] ra, input logic [2:0] rb,
                       input logic sv, input logic rs, input logic r);
    tb_we = we; tb_wa = wa; tb_wd = wd; tb_ra = ra; tb_rb = rb;
    tb_sv = sv; tb_rs = rs; tb_rst = r;
  endtask

  // Model advances one clock using the inputs held across the edge.
  task automatic model_step();
    if (tb_rst) begin
      for (int i = 0; i < 8; i++) begin
        m_main[i] = 16'h0;
        m_shadow[i] = 16'h0;
      end
      m_phase = 0; m_cnt = 0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_phase == 0) begin
        if (tb_we) m_main[tb_wa] = tb_wd;
        if (tb_sv) begin m_phase = 1; m_cnt = 0; end
        else if (tb_rs) begin m_phase = 2; m_cnt = 0; end
      end else begin
        if (m_phase == 1) m_shadow[m_cnt] = m_main[m_cnt];
        else m_main[m_cnt] = m_shadow[m_cnt];
        m_cnt++;
        if (m_cnt == 8) begin m_phase = 0; m_done = 1'b1; end
      end
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    model_step();
    @(negedge i_clk);
  endtask

  function automatic logic [15:0] exp_rd(input logic [2:0] a);
    return (tb_we && m_phase == 0 && tb_wa == a) ? tb_wd : m_main[a];
  endfunction

  task automatic check_model();
    chk("model_rdata_a", o_rdata_a, exp_rd(tb_ra));
    chk("model_rdata_b", o_rdata_b, exp_rd(tb_rb));
    chk("model_busy", {15'h0, o_busy}, {15'h0, logic'(m_phase != 0)});
    chk("model_done", {15'h0, o_done}, {15'h0, m_done});
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    drive(1'b1, a, d, a, a, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic rd(input string name, input logic [2:0] a, input logic [15:0] exp);
    drive(1'b0, 3'd0, 16'h0, a, 3'd7 - a, 1'b0, 1'b0, 1'b0);
    #1;
    chk(name, o_rdata_a, exp);
    tick();
  endtask

  // Idle for 12 cycles after a request, counting busy and done cycles.
  task automatic wait_copy(output int nb, output int nd, output int di);
    nb = 0; nd = 0; di = -1;
    for (int c = 0; c < 12; c++) begin
      drive(1'b0, 3'd0, 16'h0, 3'(c), 3'(c + 3), 1'b0, 1'b0, 1'b0);
      #1;
      check_model();
      if (o_busy) nb++;
      if (o_done) begin nd++; di = c; end
      tick();
    end
  endtask

  task automatic chk_copy(input string name, input int nb, input int nd, input int di);
    chk({name, "_busy_cycles"}, 16'(nb), 16'd8);
    chk({name, "_done_cycles"}, 16'(nd), 16'd1);
    chk({name, "_done_pos"}, 16'(di), 16'd8);
  endtask

  initial begin
    int nb, nd, di;
    logic [2:0] ra3;

    tbl[0] = '{1'b0, 3'd0, 16'h0000, 3'd0, 3'd7, 16'h0000, 16'h0000};
    tbl[1] = '{1'b1, 3'd3, 16'hBEEF, 3'd3, 3'd3, 16'hBEEF, 16'hBEEF};
    tbl[2] = '{1'b0, 3'd0, 16'h0000, 3'd3, 3'd2, 16'hBEEF, 16'h0000};
    tbl[3] = '{1'b1, 3'd2, 16'h1111, 3'd3, 3'd2, 16'hBEEF, 16'h1111};
    tbl[4] = '{1'b1, 3'd3, 16'h2222, 3'd3, 3'd3, 16'h2222, 16'h2222};
    tbl[5] = '{1'b0, 3'd0, 16'h0000, 3'd3, 3'd2, 16'h2222, 16'h1111};

    m_phase = 0; m_cnt = 0; m_done = 1'b0;
    drive(1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1);
    tick();

    drive(1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("reset_busy", {15'h0, o_busy}, 16'h0);
    chk("reset_done", {15'h0, o_done}, 16'h0);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 3'd0, 16'h0, 3'(i), 3'(7 - i), 1'b0, 1'b0, 1'b0);
      #1;
      chk("reset_rd_a", o_rdata_a, 16'h0000);
      chk("reset_rd_b", o_rdata_b, 16'h0000);
      tick();
    end

    for (int i = 0; i < 6; i++) begin
      drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].ra, tbl[i].rb, 1'b0, 1'b0, 1'b0);
      #1;
      chk("vec_rdata_a", o_rdata_a, tbl[i].ea);
      chk("vec_rdata_b", o_rdata_b, tbl[i].eb);
      chk("vec_busy", {15'h0, o_busy}, 16'h0);
      tick();
    end

    // Save a known pattern, trash the bank, restore it; poke during RESTORE.
    for (int i = 0; i < 8; i++) wr(3'(i), 16'h1000 + 16'(i));
    drive(1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0);
    tick();
    wait_copy(nb, nd, di);
    chk_copy("save", nb, nd, di);
    for (int i = 0; i < 8; i++) wr(3'(i), 16'hFFFF);
    rd("overwrite", 3'd0, 16'hFFFF);
    drive(1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0);
    tick();
    nb = 0; nd = 0; di = -1;
    for (int c = 0; c < 12; c++) begin
      if (c == 3) drive(1'b1, 3'd5, 16'h1234, 3'd5, 3'd5, 1'b1, 1'b0, 1'b0);
      else drive(1'b0, 3'd0, 16'h0, 3'd1, 3'd6, 1'b0, 1'b0, 1'b0);
      #1;
      check_model();
      if (c == 3) chk("busy_no_bypass", o_rdata_a, 16'hFFFF);
      if (o_busy) nb++;
      if (o_done) begin nd++; di = c; end
      tick();
    end
    chk_copy("restore", nb, nd, di);
    for (int i = 0; i < 8; i++) rd("restored", 3'(i), 16'h1000 + 16'(i));

    // save and restore together: SAVE wins, main untouched.
    for (int i = 0; i < 8; i++) wr(3'(i), 16'h2000 + 16'(i));
    drive(1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0);
    tick();
    wait_copy(nb, nd, di);
    chk_copy("both", nb, nd, di);
    for (int i = 0; i < 8; i++) rd("both_main", 3'(i), 16'h2000 + 16'(i));
    wr(3'd0, 16'h0000);
    drive(1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0);
    tick();
    wait_copy(nb, nd, di);
    rd("both_shadow", 3'd0, 16'h2000);

    // Write in the request cycle lands before the SAVE copies it.
    drive(1'b1, 3'd7, 16'hA5A5, 3'd7, 3'd7, 1'b1, 1'b0, 1'b0);
    #1;
    chk("req_cycle_bypass", o_rdata_a, 16'hA5A5);
    tick();
    wait_copy(nb, nd, di);
    wr(3'd7, 16'h0000);
    drive(1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0);
    tick();
    wait_copy(nb, nd, di);
    rd("save_captures_write", 3'd7, 16'hA5A5);

    // Reset mid-SAVE aborts and clears the shadow bank.
    for (int i = 0; i < 8; i++) wr(3'(i), 16'h3000 + 16'(i));
    drive(1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0);
    tick();
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("midrst_busy", {15'h0, o_busy}, 16'h0);
    chk("midrst_done", {15'h0, o_done}, 16'h0);
    tick();
    for (int i = 0; i < 8; i++) wr(3'(i), 16'h4444);
    drive(1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0);
    tick();
    wait_copy(nb, nd, di);
    for (int i = 0; i < 8; i++) rd("midrst_shadow", 3'(i), 16'h0000);

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      ra3 = 3'($urandom_range(0, 7));
      drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom()),
            ra3, ($urandom_range(0, 3) == 0) ? ra3 : 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 19) == 0),
            1'($urandom_range(0, 149) == 0));
      #1;
      check_model();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_bank_ctx.md
Name: regfile_bank_ctx

Overview:
- Parametrised general-purpose register file; successor to the single 16-bit enable-and-bypass register.
- DEPTH x WIDTH storage, one write port, two independent combinational read ports with write-to-read bypass.
- Adds a shadow bank with sequenced SAVE/RESTORE context copy (one entry per cycle, busy/done handshake).
- Sits between the control unit/ALU writeback and the operand-fetch path of the processor.

Parameters:
WIDTH, 16, data width of every register and shadow entry
ADDR_W, 3, address width; DEPTH = 2**ADDR_W registers (default 8)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
we  input  1  write enable
waddr  input  ADDR_W  write address
wdata  input  WIDTH  write data
raddr_a  input  ADDR_W  read port A address
rdata_a  output  WIDTH  read port A data (combinational)
raddr_b  input  ADDR_W  read port B address
rdata_b  output  WIDTH  read port B data (combinational)
save  input  1  request copy of main bank into shadow bank
restore  input  1  request copy of shadow bank into main bank
busy  output  1  registered; high while a SAVE/RESTORE copy runs
done  output  1  registered; one-cycle pulse when a copy completes

Behaviour:
- Reset: rst sampled high at a rising edge -> all main and shadow entries = 0, state IDLE, index = 0, busy = 0, done = 0. Reset mid-copy aborts immediately; no partial result is retained.
- Write: at a rising edge with we=1 and busy=0 -> reg[waddr] <= wdata. we while busy=1 is dropped, not queued. The producer must stall on busy.
- Read: rdata_x = (we && !busy && waddr==raddr_x) ? wdata : reg[raddr_x], for x = a and b independently.
  - Same-cycle bypass, zero latency, no register-0 special case.
  - Both ports may address the same entry.
- Reads while busy return the current main-bank contents with no bypass. During RESTORE this is a mix of old and restored entries. Consumers must not rely on it.
- FSM states: IDLE, SAVE, RESTORE. Registered index counter, ADDR_W bits.
- IDLE:
  - save=1 -> SAVE, index = 0, busy = 1.
  - Else restore=1 -> RESTORE, index = 0, busy = 1.
  - save has priority when both are asserted.
  - A write in the same cycle as the request is committed first, so a SAVE captures it.
- SAVE: each edge shadow[index] <= reg[index], index+1. On the edge copying index DEPTH-1 -> IDLE, busy = 0, done = 1, index wraps to 0.
- RESTORE: same sequencing, reg[index] <= shadow[index].
- save/restore asserted while busy are ignored (no queuing, no restart).
- Timing: request sampled at edge E0 -> busy high for exactly DEPTH cycles (edges E0..E(DEPTH-1) set/hold it) -> done high for the single cycle after edge E(DEPTH), busy low in that cycle.
- done is 0 in every other cycle. A new request may be sampled in the same cycle done is high.
- Shadow bank is not readable directly; only RESTORE exposes it.

Test Plan:
- Reset then read all 8 addresses on both ports -> rdata_a = rdata_b = 16'h0000. Assert rst mid-SAVE -> busy = 0, done = 0 next cycle, shadow cleared (verify via RESTORE giving zeros).
- we=1, waddr=3, wdata=16'hBEEF, raddr_a=3, raddr_b=3 -> both ports 16'hBEEF in the same cycle. Next cycle with we=0 -> still 16'hBEEF from storage.
- Fill reg[i] = 16'h1000+i, pulse save -> busy high exactly 8 cycles, done one cycle. Overwrite all with 16'hFFFF, pulse restore -> reg[i] = 16'h1000+i after done.
- save and restore asserted together in IDLE -> SAVE executes (main bank unchanged, shadow updated).
- During busy: we=1, waddr=5, wdata=16'h1234 -> dropped, reg[5] unchanged, no bypass on rdata. save pulsed mid-RESTORE -> ignored, busy stays exactly 8 cycles.
- we=1, waddr=7, wdata=16'hA5A5 in the same cycle as save -> shadow[7] = 16'hA5A5 after done.
